one_three_bus_demux: RTL and testbench

ONE_THREE_BUS_DEMUX -- requirements
Module: one_three_bus_demux

---
 rtl/one_three_bus_demux_pkg.sv | 34 +++
 rtl/one_three_bus_demux_if.sv | 45 ++++
 rtl/one_three_bus_demux_decode.sv | 21 ++
 rtl/one_three_bus_demux.sv | 171 +++++++++++++++++
 tb/tb_one_three_bus_demux.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/one_three_bus_demux_pkg.sv
// rtl/one_three_bus_demux_pkg.sv - shared states, target indices and address regions for the 1:3 bus demux
package one_three_bus_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int N_TARGETS = 3;

    localparam logic [1:0] TGT_RAM  = 2'd0;
    localparam logic [1:0] TGT_MMIO = 2'd1;
    localparam logic [1:0] TGT_UART = 2'd2;

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'h1;
    localparam logic [3:0] REGION_UART = 4'h2;

    // Index 3 (never a valid select) maps to no target at all.
    function automatic logic [N_TARGETS-1:0] tgt_onehot(input logic [1:0] sel);
        logic [N_TARGETS-1:0] oh;
        oh = '0;
        case (sel)
            TGT_RAM:  oh = 3'b001;
            TGT_MMIO: oh = 3'b010;
            TGT_UART: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/one_three_bus_demux_if.sv
// rtl/one_three_bus_demux_if.sv - CPU-side and target-side bus bundle for the 1:3 demux
interface one_three_bus_demux_if;
    import one_three_bus_demux_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 req_we;
    logic [3:0]           req_wstrb;

    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    logic [N_TARGETS-1:0] t_valid;
    logic [N_TARGETS-1:0] t_ready;
    logic [31:0]          t_addr;
    logic [31:0]          t_wdata;
    logic                 t_we;
    logic [3:0]           t_wstrb;

    logic [N_TARGETS-1:0] t_rsp_valid;
    logic [31:0]          t_rdata0;
    logic [31:0]          t_rdata1;
    logic [31:0]          t_rdata2;

    // The demux is the slave of the CPU and drives the target request bus.
    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output t_valid, t_addr, t_wdata, t_we, t_wstrb,
        input  t_ready, t_rsp_valid, t_rdata0, t_rdata1, t_rdata2
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  t_valid, t_addr, t_wdata, t_we, t_wstrb,
        output t_ready, t_rsp_valid, t_rdata0, t_rdata1, t_rdata2
    );

endinterface

// File: rtl/one_three_bus_demux_decode.sv
// rtl/one_three_bus_demux_decode.sv - bus_addr_decode: region nibble to target select and mapped flag
module bus_addr_decode
    import one_three_bus_demux_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [1:0] sel_o,
    output logic       mapped_o
);

    always_comb begin
        sel_o    = 2'd0;
        mapped_o = 1'b0;
        case (nibble_i)
            REGION_RAM:  begin sel_o = TGT_RAM;  mapped_o = 1'b1; end
            REGION_MMIO: begin sel_o = TGT_MMIO; mapped_o = 1'b1; end
            REGION_UART: begin sel_o = TGT_UART; mapped_o = 1'b1; end
            default:     begin sel_o = 2'd0;     mapped_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/one_three_bus_demux.sv
// rtl/one_three_bus_demux.sv - single-outstanding 1:3 request demux; DEMUX_TIMEOUT_EN adds a response watchdog
module one_three_bus_demux
    import one_three_bus_demux_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    one_three_bus_demux_if.slave bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] t_addr_q, t_addr_d;
    logic [31:0] t_wdata_q, t_wdata_d;
    logic        t_we_q, t_we_d;
    logic [3:0]  t_wstrb_q, t_wstrb_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [1:0]           dec_sel;
    logic                 dec_mapped;
    logic [N_TARGETS-1:0] sel_oh;
    logic                 tgt_hs;
    logic                 rsp_hit;
    logic [31:0]          sel_rdata;
    logic                 tmo_expired;

    bus_addr_decode u_decode (
        .nibble_i (bus.req_addr[31:28]),
        .sel_o    (dec_sel),
        .mapped_o (dec_mapped)
    );

    assign sel_oh  = tgt_onehot(sel_q);
    assign tgt_hs  = |(bus.t_ready & sel_oh);
    assign rsp_hit = |(bus.t_rsp_valid & sel_oh);

    always_comb begin
        sel_rdata = 32'h0;
        case (sel_q)
            TGT_RAM:  sel_rdata = bus.t_rdata0;
            TGT_MMIO: sel_rdata = bus.t_rdata1;
            TGT_UART: sel_rdata = bus.t_rdata2;
            default:  sel_rdata = 32'h0;
        endcase
    end

`ifdef DEMUX_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero in IDLE so it reads zero on the first REQ cycle.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = 8'd0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    assign tmo_expired = (state_q == ST_REQ || state_q == ST_WAIT) &&
                         ((tmo_cnt_q + 8'd1) == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        t_addr_d    = t_addr_q;
        t_wdata_d   = t_wdata_q;
        t_we_d      = t_we_q;
        t_wstrb_d   = t_wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    t_addr_d  = bus.req_addr;
                    t_wdata_d = bus.req_wdata;
                    t_we_d    = bus.req_we;
                    t_wstrb_d = bus.req_wstrb;
                    sel_d     = dec_sel;
                    if (dec_mapped) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end
                end
            end
            ST_REQ: begin
                if (tmo_expired) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else if (tgt_hs) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response landing on the expiry cycle still completes normally.
                if (rsp_hit) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = sel_rdata;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            t_addr_q    <= 32'h0;
            t_wdata_q   <= 32'h0;
            t_we_q      <= 1'b0;
            t_wstrb_q   <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            t_addr_q    <= t_addr_d;
            t_wdata_q   <= t_wdata_d;
            t_we_q      <= t_we_d;
            t_wstrb_q   <= t_wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign bus.t_valid   = (state_q == ST_REQ) ? sel_oh : '0;
    assign bus.t_addr    = t_addr_q;
    assign bus.t_wdata   = t_wdata_q;
    assign bus.t_we      = t_we_q;
    assign bus.t_wstrb   = t_wstrb_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_one_three_bus_demux.sv
// tb/tb_one_three_bus_demux.sv - scoreboard bench for one_three_bus_demux (DEMUX_TIMEOUT_EN selects the watchdog cases)
module tb_one_three_bus_demux;

`ifdef DEMUX_TIMEOUT_EN
    localparam int TMO  = 4;
    localparam int DMAX = 1;
`else
    localparam int TMO  = 255;
    localparam int DMAX = 4;
`endif
    localparam int RD30 = (TMO >= 5) ? 3 : 2;
    localparam int SD32 = (TMO >= 5) ? 3 : 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;

    one_three_bus_demux_if bus();

    one_three_bus_demux #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_t_valid"},   32'(bus.t_valid),   32'h0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'h0);
        chk({tag, "_t_addr"},    bus.t_addr,         32'h0);
        chk({tag, "_t_wdata"},   bus.t_wdata,        32'h0);
        chk({tag, "_t_we"},      32'(bus.t_we),      32'h0);
        chk({tag, "_t_wstrb"},   32'(bus.t_wstrb),   32'h0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    endtask

    // Monitor: every rsp_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // rd: cycles of t_valid before t_ready (-1 = never); sd: WAIT cycles before t_rsp_valid.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] wstrb, input logic [31:0] tdata,
                       input int rd, input int sd, input bit spur);
        logic [2:0] oh;
        bit         mapped;
        int         guard;
        int         idx;
        exp_t       e;
        mapped = (addr[31:28] <= 4'h2);
        idx    = int'(addr[31:28]);
        oh     = mapped ? (3'b001 << idx) : 3'b000;

        @(posedge clk); #1;
        bus.t_rsp_valid = 3'b000;
        bus.t_ready     = 3'b000;
        bus.req_valid   = 1'b1;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        bus.req_we      = we;
        bus.req_wstrb   = wstrb;
        guard = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'h1);
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end

        if (!mapped) begin
            e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1;
        end else if (rd < 0) begin
            e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1 + TMO;
        end else begin
            e.rdata = tdata; e.err = 1'b0; e.cyc = cyc + 3 + rd + sd;
        end
        exp_q.push_back(e);

        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_we    = 1'($urandom);
        bus.req_wstrb = 4'($urandom);

        if (!mapped) begin
            @(negedge clk);
            chk("unmapped_t_valid", 32'(bus.t_valid), 32'h0);
            return;
        end

        if (rd < 0) begin
            for (int k = 0; k < TMO; k++) begin
                @(negedge clk);
                chk("tmo_t_valid", 32'(bus.t_valid), 32'(oh));
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("tmo_t_valid_drop", 32'(bus.t_valid), 32'h0);
            return;
        end

        for (int k = 0; k <= rd; k++) begin
            bus.t_ready     = (k == rd) ? oh : (3'($urandom) & ~oh);
            bus.t_rsp_valid = spur ? 3'($urandom) : 3'b000;
            @(negedge clk);
            chk("t_valid", 32'(bus.t_valid), 32'(oh));
            chk("t_addr", bus.t_addr, addr);
            chk("t_wdata", bus.t_wdata, wdata);
            chk("t_we", 32'(bus.t_we), 32'(we));
            chk("t_wstrb", 32'(bus.t_wstrb), 32'(wstrb));
            @(posedge clk); #1;
        end
        bus.t_ready = 3'($urandom);

        for (int k = 0; k <= sd; k++) begin
            bus.t_rdata0 = $urandom;
            bus.t_rdata1 = $urandom;
            bus.t_rdata2 = $urandom;
            if (k == sd) begin
                bus.t_rsp_valid = oh;
                case (idx)
                    0:       bus.t_rdata0 = tdata;
                    1:       bus.t_rdata1 = tdata;
                    default: bus.t_rdata2 = tdata;
                endcase
            end else begin
                bus.t_rsp_valid = spur ? ((3'($urandom) | 3'b001) & ~oh) : 3'b000;
            end
            @(negedge clk);
            chk("wait_t_valid", 32'(bus.t_valid), 32'h0);
            @(posedge clk); #1;
        end
        bus.t_ready     = 3'b000;
        bus.t_rsp_valid = spur ? 3'($urandom) : 3'b000;
        bus.t_rdata0    = $urandom;
        bus.t_rdata1    = $urandom;
        bus.t_rdata2    = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  nib;
        logic [31:0] addr;
        int          r;
        n_checks = 0;
        n_err    = 0;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.req_we      = 1'b0;
        bus.req_wstrb   = 4'h0;
        bus.t_ready     = 3'b000;
        bus.t_rsp_valid = 3'b000;
        bus.t_rdata0    = 32'h0;
        bus.t_rdata1    = 32'h0;
        bus.t_rdata2    = 32'h0;

        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_reset", 32'(bus.req_ready), 32'h1);

        txn(32'h0000_0010, 32'h0, 1'b0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        txn(32'h1000_0004, 32'h0000_00A5, 1'b1, 4'h1, 32'h1357_9BDF, RD30, 0, 1'b0);
        txn(32'h8000_0000, 32'h1111_2222, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        txn(32'h2000_0000, 32'h0, 1'b0, 4'h0, 32'h0000_0055, 0, SD32, 1'b1);

        // Abort a transaction from WAIT with an asynchronous reset.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.req_wdata = 32'h1234_5678;
        bus.req_we    = 1'b1;
        bus.req_wstrb = 4'hF;
        @(negedge clk);
        chk("abort_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.t_ready   = 3'b001;
        @(negedge clk);
        chk("abort_t_valid", 32'(bus.t_valid), 32'h1);
        chk("abort_t_addr", bus.t_addr, 32'h0000_0100);
        @(posedge clk); #1;
        bus.t_ready = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        bus.t_rsp_valid = 3'b001;
        bus.t_rdata0    = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.t_rsp_valid = 3'b000;
        #1;
        chk("abort_req_ready_release", 32'(bus.req_ready), 32'h1);
        repeat (3) @(negedge clk);

`ifdef DEMUX_TIMEOUT_EN
        txn(32'h0000_0040, 32'h0, 1'b0, 4'h0, 32'h0BAD_0BAD, -1, 0, 1'b0);
        txn(32'h2000_0008, 32'h0, 1'b0, 4'h0, 32'h7777_0001, 0, 2, 1'b1);
        txn(32'h1000_0000, 32'h0, 1'b0, 4'h0, 32'h0000_0AAA, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 5);
            nib  = (r < 3) ? 4'(r) : 4'($urandom_range(3, 15));
            addr = {nib, 28'($urandom)};
            txn(addr, $urandom, 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, DMAX), $urandom_range(0, DMAX), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
